// File: rtl/safe_pkg.sv
// Shared types and constants for the safe datapath (p2s / s2p).
package safe_pkg;

  typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} s2p_state_t;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/s2p_if.sv
// Serial-in and parallel-out handshake bundle for the s2p deserializer.
interface s2p_if #(parameter int N = safe_pkg::DIGIT_W);

  logic         svalid;
  logic         sdata;
  logic         sready;
  logic         pvalid;
  logic [N-1:0] pdata;
  logic         pready;

  // master is the environment side: it produces serial bits and consumes words
  modport master (output svalid, sdata, pready, input sready, pvalid, pdata);
  modport slave  (input svalid, sdata, pready, output sready, pvalid, pdata);

endinterface

// File: rtl/s2p.sv
// MSB-first serial-to-parallel deserializer with a one-word output buffer.
// state   | meaning
// COLLECT | shifting serial bits in; sready = 1
// STALL   | completed word parked in sreg, obuf still held; sready = 0
module s2p
  import safe_pkg::*;
#(
  parameter int N = DIGIT_W
) (
  input  logic  clk,
  input  logic  rstn,
  s2p_if.slave  bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  s2p_state_t    r_state, w_state_nx;
  logic [N-1:0]  r_sreg, w_sreg_nx;
  logic [N-1:0]  r_obuf, w_obuf_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_pvalid, w_pvalid_nx;
  logic [N-1:0]  w_word;
  logic          w_accept;
  logic          w_drain;

  assign w_word   = {r_sreg[N-2:0], bus.sdata};
  assign w_accept = bus.svalid && (r_state == COLLECT);
  assign w_drain  = r_pvalid && bus.pready;

  always_comb begin
    w_state_nx  = r_state;
    w_sreg_nx   = r_sreg;
    w_cnt_nx    = r_cnt;
    w_obuf_nx   = r_obuf;
    w_pvalid_nx = r_pvalid;
    case (r_state)
      COLLECT: begin
        if (w_drain)
          w_pvalid_nx = 1'b0;
        if (w_accept) begin
          if (r_cnt != LAST) begin
            w_sreg_nx = w_word;
            w_cnt_nx  = r_cnt + 1'b1;
          end else begin
            w_cnt_nx = '0;
            // a draining buffer can take the new word on the same edge, no bubble
            if (!r_pvalid || bus.pready) begin
              w_obuf_nx   = w_word;
              w_pvalid_nx = 1'b1;
            end else begin
              w_sreg_nx  = w_word;
              w_state_nx = STALL;
            end
          end
        end
      end
      STALL: begin
        if (bus.pready) begin
          w_obuf_nx   = r_sreg;
          w_pvalid_nx = 1'b1;
          w_state_nx  = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= COLLECT;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      r_sreg <= w_sreg_nx;
      r_cnt  <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_obuf   <= '0;
      r_pvalid <= 1'b0;
    end else begin
      r_obuf   <= w_obuf_nx;
      r_pvalid <= w_pvalid_nx;
    end
  end

  assign bus.sready = (r_state == COLLECT);
  assign bus.pvalid = r_pvalid;
  assign bus.pdata  = r_obuf;

endmodule

// File: tb/tb_s2p.sv
// Scoreboard bench for s2p: directed words, backpressure, drain overlap, reset.
module tb_s2p;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic [3:0] q[$];

  s2p_if #(.N(4)) bus();

  s2p #(.N(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // word monitor: a transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rstn && bus.pvalid === 1'b1 && bus.pready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.pdata);
      end else begin
        logic [3:0] exp;
        exp = q.pop_front();
        chk("word", 32'(bus.pdata), 32'(exp));
      end
    end
  end

  // leaves svalid high so consecutive calls stream without gaps
  task automatic send_bit(input logic b);
    int   guard;
    logic took;
    guard = 0;
    bus.svalid = 1'b1;
    bus.sdata  = b;
    do begin
      took = bus.sready;
      @(posedge clk); #1;
      guard++;
    end while (!took && guard < 50);
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got sready 0 expected 1");
    end
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    bus.svalid = 1'b0;
  endtask

  initial begin
    logic [3:0] chain [4];
    int guard;
    checks = 0;
    errors = 0;
    chain[0] = 4'h3; chain[1] = 4'hE; chain[2] = 4'h0; chain[3] = 4'hF;

    // reset with random inputs
    rstn = 1'b0;
    bus.svalid = 1'b0; bus.sdata = 1'b0; bus.pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.svalid = 1'($urandom); bus.sdata = 1'($urandom); bus.pready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_pvalid", 32'(bus.pvalid), 0);
      chk("rst_pdata",  32'(bus.pdata),  0);
      chk("rst_sready", 32'(bus.sready), 1);
    end
    bus.svalid = 1'b0; bus.pready = 1'b1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // continuous word 1,0,1,1
    q.push_back(4'hB);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("cont_early", 32'(bus.pvalid), 0);
    send_bit(1'b1);
    bus.svalid = 1'b0;
    chk("cont_pvalid", 32'(bus.pvalid), 1);
    chk("cont_pdata",  32'(bus.pdata), 32'hB);
    @(posedge clk); #1;
    chk("cont_onecycle", 32'(bus.pvalid), 0);

    // gapped word 1,0,0,1
    q.push_back(4'h9);
    for (int i = 0; i < 4; i++) begin
      send_bit((i == 0 || i == 3) ? 1'b1 : 1'b0);
      bus.svalid = 1'b0;
      if (i < 3) begin
        repeat (2) begin
          @(posedge clk); #1;
          chk("gap_no_early", 32'(bus.pvalid), 0);
        end
      end
    end
    chk("gap_pdata", 32'(bus.pdata), 32'h9);
    @(posedge clk); #1;

    // backpressure: A held, 5 stalls
    bus.pready = 1'b0;
    q.push_back(4'hA);
    send_word(4'hA);
    chk("bp_pvalid_a", 32'(bus.pvalid), 1);
    chk("bp_pdata_a",  32'(bus.pdata), 32'hA);
    q.push_back(4'h5);
    send_word(4'h5);
    chk("bp_stall_sready", 32'(bus.sready), 0);
    chk("bp_stall_pdata",  32'(bus.pdata), 32'hA);
    bus.svalid = 1'b1; bus.sdata = 1'b1;
    @(posedge clk); #1;
    bus.svalid = 1'b0;
    chk("bp_stall_hold", 32'(bus.sready), 0);
    bus.pready = 1'b1;
    @(posedge clk); #1;
    chk("bp_exit_sready", 32'(bus.sready), 1);
    chk("bp_exit_pvalid", 32'(bus.pvalid), 1);
    chk("bp_exit_pdata",  32'(bus.pdata), 32'h5);
    @(posedge clk); #1;
    chk("bp_release", 32'(bus.pvalid), 0);

    // simultaneous drain of 3 with completion of C
    bus.pready = 1'b0;
    q.push_back(4'h3);
    send_word(4'h3);
    q.push_back(4'hC);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus.sdata = 1'b0;
    bus.pready = 1'b1;
    @(posedge clk); #1;
    bus.svalid = 1'b0;
    bus.pready = 1'b0;
    chk("sim_pvalid", 32'(bus.pvalid), 1);
    chk("sim_pdata",  32'(bus.pdata), 32'hC);
    chk("sim_sready", 32'(bus.sready), 1);
    bus.pready = 1'b1;
    @(posedge clk); #1;
    chk("sim_release", 32'(bus.pvalid), 0);

    // reset after two bits of a word
    send_bit(1'b1); send_bit(1'b1);
    bus.svalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_pvalid", 32'(bus.pvalid), 0);
    chk("mid_rst_sready", 32'(bus.sready), 1);
    rstn = 1'b1;
    @(posedge clk); #1;
    q.push_back(4'h6);
    send_word(4'h6);
    chk("mid_rst_pdata", 32'(bus.pdata), 32'h6);

    // serializer-style stream, words back to back
    for (int w = 0; w < 4; w++) begin
      q.push_back(chain[w]);
      for (int i = 3; i >= 0; i--) send_bit(chain[w][i]);
    end
    bus.svalid = 1'b0;

    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2p.md
# s2p

Serial-to-parallel deserializer for the digital safe datapath, sitting directly downstream of the `p2s` serializer. It collects MSB-first serial bits under a valid/ready handshake and presents each completed N-bit word on a parallel valid/ready port, e.g. toward the code-compare logic. A one-word output buffer lets it accept the next word while the previous one is held, so it runs at full rate when the consumer keeps `pready` high.

## Interface
- `N`, default 4: word width in bits. Legal range is N >= 2.
- `clk`  in  1  the only clock. Everything is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `svalid`  in  1  the serial bit on `sdata` is valid.
- `sdata`  in  1  serial data, MSB first.
- `sready`  out  1  the block can accept a serial bit. Driven only from state (registered).
- `pvalid`  out  1  `pdata` holds a completed word.
- `pdata`  out  N  the completed word.
- `pready`  in  1  the consumer accepts `pdata`.

## Operation
- **Serial transfer:** a bit transfers on a rising edge where `svalid && sready`. Parallel transfer happens when `pvalid && pready`.
- **Internal state:**
  - shift register `sreg[N-1:0]`
  - bit counter `cnt`, width `$clog2(N)`
  - output buffer `obuf`, which drives `pdata`
  - valid flag, which drives `pvalid`
  - FSM state
- **FSM states:** COLLECT and STALL. `sready` is 1 in COLLECT and 0 in STALL.
- **COLLECT, bit accepted with `cnt < N-1`:**
  - `sreg <= {sreg[N-2:0], sdata}`
  - `cnt <= cnt + 1`
- **COLLECT, bit accepted with `cnt == N-1` (word complete, word `W = {sreg[N-2:0], sdata}`), and `cnt <= 0`:**
  - If `!pvalid || pready`: `obuf <= W`, `pvalid <= 1`, stay in COLLECT.
  - Otherwise: `sreg <= W` and go to STALL.
- **STALL:**
  - Serial inputs are ignored.
  - On `pready`: `obuf <= sreg`, `pvalid` stays 1, return to COLLECT.
- **Word release:** if `pvalid && pready` and no new word loads in the same cycle, `pvalid <= 0`.
- **Gaps:** `svalid` low cycles are allowed anywhere. `cnt` and `sreg` hold during them.
- **Reset mid-word:** a partial word is discarded and `cnt` returns to 0. A buffered or stalled word is also discarded.
- **Upstream compatibility:** `sready` stays high for the whole word in COLLECT, so an upstream serializer that requires `sready` on its last bit always completes.

## Timing
- **Reset values:**
  - `pvalid = 0`
  - `pdata = '0`
  - `sready = 1` (state COLLECT)
  - `cnt = 0`
  - `sreg = '0`
- **Latency:** `pvalid` rises on the edge that accepts the Nth bit, so `pdata` is visible in the cycle after the last bit is presented.
- **Throughput:** one word per N cycles with no bubbles while `pready` is high.
- **Simultaneous completion and drain:** if the word-complete edge coincides with `pvalid && pready`, the new word replaces the old one and `pvalid` stays 1.
- **STALL exit:** takes one cycle after `pready`. `sready` returns to 1 on the same edge that moves the stalled word into `obuf`.
- **Combinational paths:** there is no combinational path from `pready` or `svalid` to any output.

## Structure
- Shared package `safe_pkg`:
  - `typedef enum logic {COLLECT=1'b0, STALL=1'b1} s2p_state_t`
  - `localparam DIGIT_W = 4`, used as the default N by both `p2s` and `s2p`.
- Single module with no sub-module. The shift register, counter, output buffer and FSM are each a small `always_ff` / `always_comb` group.
- The integration bench instantiates `p2s` → `s2p` back to back, connecting `svalid` / `sready` / `sdata`.

## Test plan
- **Reset:** assert `rstn=0` with random inputs → `pvalid=0`, `pdata=0`, `sready=1`.
- **Continuous word:** `pready=1`, send bits 1,0,1,1 on consecutive cycles → `pdata=4'hB`. `pvalid` is high for exactly one cycle, starting the cycle after the 4th bit.
- **Gapped input:** bits 1,0,0,1 with 2 idle `svalid=0` cycles between each → `pdata=4'h9`. No early `pvalid`.
- **Backpressure:** `pready=0`, send `4'hA` then `4'h5` → after the 2nd word `sready=0` (STALL) and `pdata=A`. Raise `pready` → A, then 5, delivered on consecutive cycles, and `sready` returns to 1.
- **Simultaneous drain:** hold `pdata=4'h3` valid, pulse `pready` on the same edge the last bit of `4'hC` is accepted → next cycle `pdata=C`, `pvalid=1`, no bubble.
- **Reset mid-word:** reset after 2 bits, then send `4'h6` → `pdata=4'h6`. Chained `p2s`→`s2p` with `pdata` 3,E,0,F returns 3,E,0,F in order.
